instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction decoder.
- Owns the program counter, issues word requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned words in a small FIFO.
- Presents {instruction, pc, fault} to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from execute, which flush all in-flight and buffered work.

---
 rtl/instr_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem req/gnt/rvalid handshake, instruction FIFO.
// Optional execute-permission window check enabled by defining FETCH_PMP_EXEC_CHECK_EN.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        imem_err,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
`ifdef FETCH_PMP_EXEC_CHECK_EN
   input  logic [31:0] pmp_x_base,
   input  logic [31:0] pmp_x_limit,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        out_fault
);

   localparam int          AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int          CW  = AW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD, S_HALT} state_t;

   state_t          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     req_pc_q, req_pc_d;
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   rptr_q, rptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic [31:0]     fifo_instr_q [FIFO_DEPTH];
   logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
   logic            fifo_fault_q [FIFO_DEPTH];

   logic            push, pop, flush, granted, slot_free, pmp_block;
   logic [31:0]     push_instr, push_pc;
   logic            push_fault;
   logic            unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Requests are only issued from REQ, where nothing is outstanding, so a
   // free slot reduces to count < depth and every response has room.
   assign slot_free = (count_q < CW'(FIFO_DEPTH));
   assign imem_addr = pc_q;
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      push       = 1'b0;
      push_instr = imem_rdata;
      push_pc    = req_pc_q;
      push_fault = 1'b0;
      flush      = 1'b0;
      pmp_block  = 1'b0;
`ifdef FETCH_PMP_EXEC_CHECK_EN
      pmp_block  = (pc_q < pmp_x_base) || (pc_q >= pmp_x_limit);
`endif
      imem_req   = !rst && (state_q == S_REQ) && slot_free && !pmp_block;
      granted    = imem_req && imem_gnt;

      if (redirect_valid) begin
         flush = 1'b1;
         pc_d  = {redirect_pc[31:2], 2'b00};
         // A response landing on the redirect edge completes the old request,
         // so only a still-pending request needs its response discarded.
         if (granted || (((state_q == S_WAIT) || (state_q == S_DISCARD)) && !imem_rvalid))
            state_d = S_DISCARD;
         else
            state_d = S_REQ;
      end else begin
         case (state_q)
            S_REQ: begin
               if (pmp_block) begin
                  if (slot_free) begin
                     push       = 1'b1;
                     push_instr = NOP;
                     push_pc    = pc_q;
                     push_fault = 1'b1;
                     state_d    = S_HALT;
                  end
               end else if (granted) begin
                  req_pc_d = pc_q;
                  pc_d     = pc_q + 32'd4;
                  state_d  = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  push       = 1'b1;
                  push_fault = imem_err;
                  push_instr = imem_err ? NOP : imem_rdata;
                  state_d    = imem_err ? S_HALT : S_REQ;
               end
            end
            S_DISCARD: begin
               if (imem_rvalid) state_d = S_REQ;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_REQ;
         endcase
      end

      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop)  rptr_d = rptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_q[wptr_q] <= push_instr;
         fifo_pc_q[wptr_q]    <= push_pc;
         fifo_fault_q[wptr_q] <= push_fault;
      end
   end

   // Storage is not reset; masking with out_valid keeps outputs zero when empty.
   assign out_valid = (count_q != '0);
   assign out_instr = out_valid ? fifo_instr_q[rptr_q] : 32'h0;
   assign out_pc    = out_valid ? fifo_pc_q[rptr_q]    : 32'h0;
   assign out_fault = out_valid && fifo_fault_q[rptr_q];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (PMP scenario when FETCH_PMP_EXEC_CHECK_EN is defined).
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        imem_err = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_fault;
`ifdef FETCH_PMP_EXEC_CHECK_EN
   logic [31:0] pmp_x_base  = 32'h0;
   logic [31:0] pmp_x_limit = 32'hFFFF_FFFF;
`endif

   int checks = 0;
   int errors = 0;

   instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef FETCH_PMP_EXEC_CHECK_EN
      .pmp_x_base(pmp_x_base), .pmp_x_limit(pmp_x_limit),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_fault(out_fault)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout reached without finishing");
      $fatal(1, "timeout");
   end

   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      imem_gnt = 0; imem_rvalid = 0; imem_err = 0; redirect_valid = 0; out_ready = 0;
      rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
   endtask

   // One request granted immediately, answered one cycle later; ends with the entry visible.
   task automatic fetch_one(input logic [31:0] d, input logic e);
      imem_gnt = 1;
      nxt();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = d; imem_err = e;
      nxt();
      imem_rvalid = 0; imem_err = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", imem_req); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", out_valid); end
      checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", out_instr); end
      checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", out_pc); end
      checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %0b exp 0", out_fault); end
      @(negedge clk);
      rst = 0;
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %0b exp 1", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h exp 0", imem_addr); end
   endtask

   task automatic test_basic();
      do_reset();
      out_ready = 1;
      imem_gnt = 1;
      nxt();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_wait_req got %0b exp 0", imem_req); end
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0050_0093;
      nxt();
      imem_rvalid = 0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", out_valid); end
      checks++; if (out_instr !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr got %h exp 00500093", out_instr); end
      checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL basic_pc got %h exp 0", out_pc); end
      checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL basic_fault got %0b exp 0", out_fault); end
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL basic_addr4 got %h exp 4", imem_addr); end
      fetch_one(32'h00A0_0113, 1'b0);
      checks++; if (out_instr !== 32'h00A0_0113) begin errors++; $display("FAIL basic_instr2 got %h exp 00a00113", out_instr); end
      checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL basic_pc2 got %h exp 4", out_pc); end
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL basic_addr8 got %h exp 8", imem_addr); end
      nxt();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got %0b exp 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 0;
      imem_gnt = 1;
      nxt();
      imem_rvalid = 1; imem_rdata = 32'hA000_0000;
      nxt();
      imem_rvalid = 0;
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL b2b_addr4 got %h exp 4", imem_addr); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL b2b_req1 got %0b exp 1", imem_req); end
      nxt();
      imem_rvalid = 1; imem_rdata = 32'hA000_0001;
      nxt();
      imem_rvalid = 0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_full_req got %0b exp 0", imem_req); end
      checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL b2b_head0 got %h exp 0", out_pc); end
      checks++; if (out_instr !== 32'hA000_0000) begin errors++; $display("FAIL b2b_instr0 got %h exp a0000000", out_instr); end
      nxt();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_full_req2 got %0b exp 0", imem_req); end
      checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL b2b_head0b got %h exp 0", out_pc); end
      out_ready = 1;
      nxt();
      checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL b2b_head4 got %h exp 4", out_pc); end
      checks++; if (out_instr !== 32'hA000_0001) begin errors++; $display("FAIL b2b_instr1 got %h exp a0000001", out_instr); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL b2b_req8 got req %0b addr %h exp 1 8", imem_req, imem_addr); end
      nxt();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b exp 0", out_valid); end
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hA000_0002;
      nxt();
      imem_rvalid = 0;
      checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL b2b_head8 got %h exp 8", out_pc); end
      checks++; if (out_instr !== 32'hA000_0002) begin errors++; $display("FAIL b2b_instr2 got %h exp a0000002", out_instr); end
      nxt();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_nodup got %0b exp 0", out_valid); end
   endtask

   task automatic test_redirect();
      do_reset();
      out_ready = 0;
      imem_gnt = 1;
      nxt();
      imem_gnt = 0; redirect_valid = 1; redirect_pc = 32'h0000_0103;
      nxt();
      redirect_valid = 0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_disc_req got %0b exp 0", imem_req); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_disc_valid got %0b exp 0", out_valid); end
      imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
      nxt();
      imem_rvalid = 0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_dropped got %0b exp 0", out_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got req %0b addr %h exp 1 100", imem_req, imem_addr); end
      fetch_one(32'hB000_0000, 1'b0);
      checks++; if (out_pc !== 32'h100 || out_instr !== 32'hB000_0000) begin errors++; $display("FAIL redir_new got pc %h instr %h exp 100 b0000000", out_pc, out_instr); end
      out_ready = 1; redirect_valid = 1; redirect_pc = 32'h0000_0200;
      nxt();
      redirect_valid = 0; out_ready = 0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %0b exp 0", out_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL redir_addr200 got req %0b addr %h exp 1 200", imem_req, imem_addr); end
   endtask

   task automatic test_fault();
      do_reset();
      out_ready = 1;
      fetch_one(32'h0000_1111, 1'b0);
      fetch_one(32'h0000_2222, 1'b0);
      checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL fault_pre_pc got %h exp 4", out_pc); end
      fetch_one(32'hFFFF_FFFF, 1'b1);
      out_ready = 0;
      checks++; if (out_instr !== 32'h0000_0013) begin errors++; $display("FAIL fault_instr got %h exp 00000013", out_instr); end
      checks++; if (out_fault !== 1'b1) begin errors++; $display("FAIL fault_flag got %0b exp 1", out_fault); end
      checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL fault_pc got %h exp 8", out_pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fault_req got %0b exp 0", imem_req); end
      nxt();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req got %0b exp 0", imem_req); end
      redirect_valid = 1; redirect_pc = 32'h0000_0040;
      nxt();
      redirect_valid = 0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL halt_flush got %0b exp 0", out_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL halt_resume got req %0b addr %h exp 1 40", imem_req, imem_addr); end
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      out_ready = 0;
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
      nxt();
      redirect_valid = 0;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
      fetch_one(32'hC000_0000, 1'b0);
      checks++; if (out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", out_pc); end
      checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_next got req %0b addr %h exp 1 0", imem_req, imem_addr); end
      imem_gnt = 1;
      nxt();
      imem_gnt = 0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_wait_req got %0b exp 0", imem_req); end
      rst = 1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || out_fault !== 1'b0) begin errors++; $display("FAIL async_rst_out got v%0b i%h p%h f%0b exp zeros", out_valid, out_instr, out_pc, out_fault); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_rst_req got %0b exp 0", imem_req); end
      nxt();
      rst = 0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL restart got req %0b addr %h exp 1 0", imem_req, imem_addr); end
      imem_rvalid = 1; imem_rdata = 32'hEEEE_EEEE;
      nxt();
      imem_rvalid = 0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL late_rvalid got %0b exp 0", out_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL late_addr got req %0b addr %h exp 1 0", imem_req, imem_addr); end
   endtask

`ifdef FETCH_PMP_EXEC_CHECK_EN
   task automatic test_pmp();
      do_reset();
      out_ready = 1;
      pmp_x_base = 32'h100; pmp_x_limit = 32'h108;
      redirect_valid = 1; redirect_pc = 32'h100;
      nxt();
      redirect_valid = 0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL pmp_addr100 got req %0b addr %h exp 1 100", imem_req, imem_addr); end
      fetch_one(32'hD000_0000, 1'b0);
      checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL pmp_pc100 got %h exp 100", out_pc); end
      fetch_one(32'hD000_0001, 1'b0);
      checks++; if (out_pc !== 32'h104) begin errors++; $display("FAIL pmp_pc104 got %h exp 104", out_pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL pmp_block_req got %0b exp 0", imem_req); end
      nxt();
      checks++; if (out_pc !== 32'h108 || out_fault !== 1'b1 || out_instr !== 32'h13) begin errors++; $display("FAIL pmp_entry got pc %h f %0b i %h exp 108 1 13", out_pc, out_fault, out_instr); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL pmp_req2 got %0b exp 0", imem_req); end
      nxt();
      checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL pmp_halt got req %0b valid %0b exp 0 0", imem_req, out_valid); end
      pmp_x_base = 32'h0; pmp_x_limit = 32'hFFFF_FFFF;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_redirect();
      test_fault();
      test_wrap_and_reset();
`ifdef FETCH_PMP_EXEC_CHECK_EN
      test_pmp();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
